multicycle_control: RTL and testbench

- Parametrised multi-cycle control unit for the RV64I datapath: register bank, ULA, ULAPC, ProgramCounter, instruction register and data memory.
- Replaces hand-sequenced per-instruction control with an FSM that decodes the instruction register and drives all datapath enables and selects.
- Covers ld, sd, add, sub, addi, jal, jalr, auipc, beq and bne.
- Adds configurable memory wait states, a single-step mode, illegal-instruction halt and a retired-instruction counter.

---
 rtl/multicycle_control.sv | 252 +++++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multi-cycle FSM control unit for the RV64I datapath (ld/sd/add/sub/addi/jal/jalr/auipc/beq/bne).
// Optional TRACE_RETIRE_EN adds last_pc_sel/last_instr retirement trace ports and a sim-only log.
module multicycle_control #(
  parameter int MEM_LAT = 1,
  parameter int REG_AW  = 5,
  parameter int RET_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              step,
  input  logic [31:0]       instr,
  input  logic              zero,
  output logic              ir_we,
  output logic              pc_we,
  output logic [1:0]        pc_sel,
  output logic              reg_we,
  output logic [REG_AW-1:0] rs1,
  output logic [REG_AW-1:0] rs2,
  output logic [REG_AW-1:0] rd,
  output logic [1:0]        wb_sel,
  output logic [2:0]        imm_sel,
  output logic              alu_sub,
  output logic              alu_imm,
  output logic              mem_re,
  output logic              mem_we,
  output logic              busy,
  output logic              illegal,
  output logic [RET_W-1:0]  retired
`ifdef TRACE_RETIRE_EN
  ,
  output logic [1:0]        last_pc_sel,
  output logic [31:0]       last_instr
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM_WAIT, S_WB, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    C_NONE, C_LD, C_SD, C_ADD, C_SUB, C_ADDI, C_JAL, C_JALR, C_AUIPC, C_BEQ, C_BNE
  } iclass_t;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_MEM  = 2'd1;
  localparam logic [1:0] WB_PC4  = 2'd2;
  localparam logic [1:0] WB_PCIM = 2'd3;

  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_IMM   = 2'd1;
  localparam logic [1:0] PC_JALR  = 2'd2;

  localparam logic [3:0] CNT_LAST = 4'(MEM_LAT - 1);

  state_t           state, state_nx;
  iclass_t          cls, dec_class;
  logic [3:0]       cnt;
  logic             cnt_last;
  logic             instr_end;
  logic             rd_nz;

  wire [6:0] opcode = instr[6:0];
  wire [2:0] funct3 = instr[14:12];
  wire [6:0] funct7 = instr[31:25];

  assign cnt_last = (cnt == CNT_LAST);
  assign rd_nz    = |rd;
  assign busy     = (state != S_IDLE) && (state != S_HALT);

  // Instruction classification from the instruction register; C_NONE means illegal.
  always_comb begin
    dec_class = C_NONE;
    case (opcode)
      7'b0000011: if (funct3 == 3'b011) dec_class = C_LD;
      7'b0100011: if (funct3 == 3'b011) dec_class = C_SD;
      7'b0110011: begin
        if (funct3 == 3'b000 && funct7 == 7'b0000000) dec_class = C_ADD;
        else if (funct3 == 3'b000 && funct7 == 7'b0100000) dec_class = C_SUB;
      end
      7'b0010011: if (funct3 == 3'b000) dec_class = C_ADDI;
      7'b1101111: dec_class = C_JAL;
      7'b1100111: if (funct3 == 3'b000) dec_class = C_JALR;
      7'b0010111: dec_class = C_AUIPC;
      7'b1100011: begin
        if (funct3 == 3'b000) dec_class = C_BEQ;
        else if (funct3 == 3'b001) dec_class = C_BNE;
      end
      default: dec_class = C_NONE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cls     <= C_NONE;
      rs1     <= '0;
      rs2     <= '0;
      rd      <= '0;
      cnt     <= '0;
      retired <= '0;
      illegal <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == S_DECODE) begin
        cls <= dec_class;
        rs1 <= REG_AW'(instr[19:15]);
        rs2 <= REG_AW'(instr[24:20]);
        rd  <= REG_AW'(instr[11:7]);
        if (dec_class == C_NONE) illegal <= 1'b1;
      end
      // Wait-state counter restarts whenever MEM_WAIT is left.
      if (state == S_MEM_WAIT && !cnt_last) cnt <= cnt + 4'd1;
      else                                  cnt <= '0;
      if (instr_end) retired <= retired + RET_W'(1);
    end
  end

  // NOTE: every output and next-state value gets a default first, so no path infers a latch.
  always_comb begin
    state_nx  = state;
    instr_end = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = PC_PLUS4;
    reg_we    = 1'b0;
    wb_sel    = WB_ALU;
    imm_sel   = IMM_I;
    alu_sub   = 1'b0;
    alu_imm   = 1'b0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;

    case (state)
      S_IDLE:   if (start) state_nx = S_FETCH;
      S_FETCH: begin
        ir_we    = 1'b1;
        state_nx = S_DECODE;
      end
      S_DECODE: state_nx = (dec_class == C_NONE) ? S_HALT : S_EXEC;
      S_EXEC: begin
        case (cls)
          C_ADD, C_SUB: begin
            alu_sub  = (cls == C_SUB);
            state_nx = S_WB;
          end
          C_ADDI: begin
            alu_imm  = 1'b1;
            state_nx = S_WB;
          end
          C_AUIPC: begin
            imm_sel  = IMM_U;
            state_nx = S_WB;
          end
          C_LD: begin
            alu_imm  = 1'b1;
            state_nx = S_MEM_WAIT;
          end
          C_SD: begin
            imm_sel  = IMM_S;
            alu_imm  = 1'b1;
            state_nx = S_MEM_WAIT;
          end
          C_BEQ, C_BNE: begin
            alu_sub   = 1'b1;
            imm_sel   = IMM_B;
            pc_we     = 1'b1;
            pc_sel    = ((cls == C_BEQ) == zero) ? PC_IMM : PC_PLUS4;
            instr_end = 1'b1;
          end
          C_JAL: begin
            imm_sel   = IMM_J;
            pc_sel    = PC_IMM;
            pc_we     = 1'b1;
            wb_sel    = WB_PC4;
            reg_we    = rd_nz;
            instr_end = 1'b1;
          end
          C_JALR: begin
            pc_sel    = PC_JALR;
            pc_we     = 1'b1;
            wb_sel    = WB_PC4;
            reg_we    = rd_nz;
            instr_end = 1'b1;
          end
          default: state_nx = S_HALT;
        endcase
      end
      S_MEM_WAIT: begin
        alu_imm = 1'b1;
        if (cls == C_SD) begin
          imm_sel = IMM_S;
          mem_we  = (cnt == 4'd0);
          if (cnt_last) begin
            pc_we     = 1'b1;
            instr_end = 1'b1;
          end
        end else begin
          mem_re = 1'b1;
          if (cnt_last) state_nx = S_WB;
        end
      end
      S_WB: begin
        reg_we    = rd_nz;
        pc_we     = 1'b1;
        instr_end = 1'b1;
        // ALU controls stay applied so the combinational result is still valid for write-back.
        case (cls)
          C_LD:    wb_sel = WB_MEM;
          C_AUIPC: begin
            wb_sel  = WB_PCIM;
            imm_sel = IMM_U;
          end
          C_ADDI:  alu_imm = 1'b1;
          C_SUB:   alu_sub = 1'b1;
          default: wb_sel = WB_ALU;
        endcase
      end
      S_HALT:   state_nx = S_HALT;
      default:  state_nx = S_IDLE;
    endcase

    if (instr_end) state_nx = step ? S_IDLE : S_FETCH;
  end

`ifdef TRACE_RETIRE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_pc_sel <= 2'd0;
      last_instr  <= 32'd0;
    end else if (instr_end) begin
      last_pc_sel <= pc_sel;
      last_instr  <= instr;
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst_n && instr_end)
      $display("retire #%0d instr=%08h pc_sel=%0d", retired + RET_W'(1), instr, pc_sel);
  end
`endif
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control (MEM_LAT = 3).
module tb_multicycle_control;

  logic        clk, rst_n, start, step, zero;
  logic [31:0] instr;
  logic        ir_we, pc_we, reg_we, alu_sub, alu_imm, mem_re, mem_we, busy, illegal;
  logic [1:0]  pc_sel, wb_sel;
  logic [2:0]  imm_sel;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] retired;
`ifdef TRACE_RETIRE_EN
  logic [1:0]  last_pc_sel;
  logic [31:0] last_instr;
`endif

  multicycle_control #(.MEM_LAT(3), .REG_AW(5), .RET_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .step(step), .instr(instr), .zero(zero),
    .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .reg_we(reg_we),
    .rs1(rs1), .rs2(rs2), .rd(rd), .wb_sel(wb_sel), .imm_sel(imm_sel),
    .alu_sub(alu_sub), .alu_imm(alu_imm), .mem_re(mem_re), .mem_we(mem_we),
    .busy(busy), .illegal(illegal), .retired(retired)
`ifdef TRACE_RETIRE_EN
    , .last_pc_sel(last_pc_sel), .last_instr(last_instr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int exp_ret  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Per-instruction observations gathered by run_instr (cycle 1 = FETCH).
  int         n_cyc, n_re, n_we, n_reg, n_pc, n_ir;
  int         c_re_first, c_we, c_pc;
  logic [1:0] wb_at_reg, psel_at_pc;
  logic [4:0] rd_at_reg;
  logic       sub_ex, imm_ex_b;
  logic [2:0] imm_ex;

  task automatic run_instr(input logic [31:0] ins, input logic z);
    instr = ins; zero = z; step = 1'b1; start = 1'b1;
    n_cyc = 0; n_re = 0; n_we = 0; n_reg = 0; n_pc = 0; n_ir = 0;
    c_re_first = 0; c_we = 0; c_pc = 0;
    wb_at_reg = '0; psel_at_pc = '0; rd_at_reg = '0;
    sub_ex = 1'b0; imm_ex_b = 1'b0; imm_ex = '0;
    cyc();
    start = 1'b0;
    while (busy && n_cyc < 40) begin
      n_cyc++;
      if (ir_we) n_ir++;
      if (mem_re) begin n_re++; if (c_re_first == 0) c_re_first = n_cyc; end
      if (mem_we) begin n_we++; c_we = n_cyc; end
      if (reg_we) begin n_reg++; wb_at_reg = wb_sel; rd_at_reg = rd; end
      if (pc_we)  begin n_pc++; c_pc = n_cyc; psel_at_pc = pc_sel; end
      if (n_cyc == 3) begin sub_ex = alu_sub; imm_ex_b = alu_imm; imm_ex = imm_sel; end
      cyc();
    end
    if (n_cyc >= 40) check("timeout", 64'(n_cyc), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; step = 1'b1; zero = 1'b0; instr = 32'h0;
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_retired", 64'(retired), 64'd0);
    check("rst_illegal", 64'(illegal), 64'd0);
    check("rst_rd", 64'(rd), 64'd0);
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
    check("idle_ir_we", 64'(ir_we), 64'd0);

    // addi x3,x0,5 stepped cycle by cycle
    instr = 32'h00500193; step = 1'b1; start = 1'b1;
    cyc(); start = 1'b0;
    check("addi_c1_ir_we", 64'(ir_we), 64'd1);
    check("addi_c1_busy", 64'(busy), 64'd1);
    cyc();
    check("addi_c2_ir_we", 64'(ir_we), 64'd0);
    cyc();
    check("addi_c3_alu_imm", 64'(alu_imm), 64'd1);
    check("addi_c3_imm_sel", 64'(imm_sel), 64'd0);
    check("addi_c3_reg_we", 64'(reg_we), 64'd0);
    cyc();
    check("addi_wb_reg_we", 64'(reg_we), 64'd1);
    check("addi_wb_rd", 64'(rd), 64'd3);
    check("addi_wb_wb_sel", 64'(wb_sel), 64'd0);
    check("addi_wb_pc_we", 64'(pc_we), 64'd1);
    check("addi_wb_pc_sel", 64'(pc_sel), 64'd0);
    check("addi_wb_retired", 64'(retired), 64'd0);
    cyc();
    exp_ret = 1;
    check("addi_idle_busy", 64'(busy), 64'd0);
    check("addi_retired", 64'(retired), 64'(exp_ret));

    // ld x5,8(x2)
    run_instr(32'h00813283, 1'b0); exp_ret++;
    check("ld_cycles", 64'(n_cyc), 64'd7);
    check("ld_mem_re_cnt", 64'(n_re), 64'd3);
    check("ld_mem_re_first", 64'(c_re_first), 64'd4);
    check("ld_imm_sel", 64'(imm_ex), 64'd0);
    check("ld_alu_imm", 64'(imm_ex_b), 64'd1);
    check("ld_reg_we_cnt", 64'(n_reg), 64'd1);
    check("ld_wb_sel", 64'(wb_at_reg), 64'd1);
    check("ld_rd", 64'(rd_at_reg), 64'd5);
    check("ld_pc_we_cycle", 64'(c_pc), 64'd7);
    check("ld_mem_we_cnt", 64'(n_we), 64'd0);
    check("ld_retired", 64'(retired), 64'(exp_ret));

    // sd x5,0(x2)
    run_instr(32'h00513023, 1'b0); exp_ret++;
    check("sd_cycles", 64'(n_cyc), 64'd6);
    check("sd_mem_we_cnt", 64'(n_we), 64'd1);
    check("sd_mem_we_cycle", 64'(c_we), 64'd4);
    check("sd_pc_we_cnt", 64'(n_pc), 64'd1);
    check("sd_pc_we_cycle", 64'(c_pc), 64'd6);
    check("sd_pc_sel", 64'(psel_at_pc), 64'd0);
    check("sd_reg_we_cnt", 64'(n_reg), 64'd0);
    check("sd_imm_sel", 64'(imm_ex), 64'd1);
    check("sd_retired", 64'(retired), 64'(exp_ret));

    // beq x1,x2,+8 taken / not taken
    run_instr(32'h00208463, 1'b1); exp_ret++;
    check("beq_t_cycles", 64'(n_cyc), 64'd3);
    check("beq_t_pc_sel", 64'(psel_at_pc), 64'd1);
    check("beq_t_alu_sub", 64'(sub_ex), 64'd1);
    check("beq_t_imm_sel", 64'(imm_ex), 64'd2);
    run_instr(32'h00208463, 1'b0); exp_ret++;
    check("beq_nt_pc_we", 64'(n_pc), 64'd1);
    check("beq_nt_pc_sel", 64'(psel_at_pc), 64'd0);
    check("beq_nt_reg_we", 64'(n_reg), 64'd0);

    // bne x1,x2,+8 with zero = 0 -> taken
    run_instr(32'h00209463, 1'b0); exp_ret++;
    check("bne_t_pc_sel", 64'(psel_at_pc), 64'd1);

    // jal x0,+16 and jal x1,+16
    run_instr(32'h0100006F, 1'b0); exp_ret++;
    check("jal0_cycles", 64'(n_cyc), 64'd3);
    check("jal0_pc_we", 64'(n_pc), 64'd1);
    check("jal0_pc_sel", 64'(psel_at_pc), 64'd1);
    check("jal0_reg_we", 64'(n_reg), 64'd0);
    check("jal0_imm_sel", 64'(imm_ex), 64'd4);
    run_instr(32'h010000EF, 1'b0); exp_ret++;
    check("jal1_reg_we", 64'(n_reg), 64'd1);
    check("jal1_wb_sel", 64'(wb_at_reg), 64'd2);

    // jalr x1,0(x5)
    run_instr(32'h000280E7, 1'b0); exp_ret++;
    check("jalr_cycles", 64'(n_cyc), 64'd3);
    check("jalr_pc_sel", 64'(psel_at_pc), 64'd2);
    check("jalr_wb_sel", 64'(wb_at_reg), 64'd2);

    // sub x3,x1,x2 ; auipc x4,1 ; addi x0,x0,0
    run_instr(32'h402081B3, 1'b0); exp_ret++;
    check("sub_cycles", 64'(n_cyc), 64'd4);
    check("sub_alu_sub", 64'(sub_ex), 64'd1);
    check("sub_alu_imm", 64'(imm_ex_b), 64'd0);
    check("sub_wb_sel", 64'(wb_at_reg), 64'd0);
    run_instr(32'h00001217, 1'b0); exp_ret++;
    check("auipc_imm_sel", 64'(imm_ex), 64'd3);
    check("auipc_wb_sel", 64'(wb_at_reg), 64'd3);
    run_instr(32'h00000013, 1'b0); exp_ret++;
    check("nop_reg_we", 64'(n_reg), 64'd0);
    check("nop_pc_we", 64'(n_pc), 64'd1);
    check("alu_retired", 64'(retired), 64'(exp_ret));

    // step = 0 continues straight into the next FETCH without start
    instr = 32'h00000013; step = 1'b0; start = 1'b1;
    cyc(); start = 1'b0;
    cyc(); cyc(); cyc();
    cyc();
    exp_ret++;
    check("cont_ir_we", 64'(ir_we), 64'd1);
    check("cont_retired", 64'(retired), 64'(exp_ret));
    step = 1'b1;
    cyc(); cyc(); cyc(); cyc();
    exp_ret++;
    check("cont_idle_busy", 64'(busy), 64'd0);
    check("cont_retired2", 64'(retired), 64'(exp_ret));

    // Illegal instruction halts; start ignored
    run_instr(32'hFFFFFFFF, 1'b0);
    check("ill_cycles", 64'(n_cyc), 64'd2);
    check("ill_illegal", 64'(illegal), 64'd1);
    start = 1'b1; cyc(); cyc(); start = 1'b0;
    check("ill_start_ignored", 64'(ir_we), 64'd0);
    check("ill_busy", 64'(busy), 64'd0);
    check("ill_still", 64'(illegal), 64'd1);
    check("ill_retired", 64'(retired), 64'(exp_ret));
    #1 rst_n = 1'b0;
    #1;
    check("ill_rst_illegal", 64'(illegal), 64'd0);
    check("ill_rst_retired", 64'(retired), 64'd0);
    cyc();
    rst_n = 1'b1;
    cyc();
    check("ill_rst_idle", 64'(busy), 64'd0);

    // Reset in the first MEM_WAIT cycle of sd drops mem_we without a clock edge
    instr = 32'h00513023; step = 1'b1; start = 1'b1;
    cyc(); start = 1'b0;
    cyc(); cyc(); cyc();
    check("sdrst_mem_we_pre", 64'(mem_we), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check("sdrst_mem_we", 64'(mem_we), 64'd0);
    check("sdrst_busy", 64'(busy), 64'd0);
    check("sdrst_retired", 64'(retired), 64'd0);
    cyc();
    rst_n = 1'b1;
    cyc();
    check("sdrst_idle", 64'(busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
